// File: rtl/vram_copy_engine.sv
// Word-granular VRAM copy/fill engine. It shares VRAM port 0 with the CPU
// register path; the CPU always wins and the DMA sequencer uses idle cycles.
module vram_copy_engine (
  input  logic        clk,
  input  logic        rst,
  input  logic [14:0] cfg_src,
  input  logic [14:0] cfg_dst,
  input  logic [14:0] cfg_len,
  input  logic        cfg_fill_mode,
  input  logic [31:0] cfg_fill_data,
  input  logic        start,
  output logic        busy,
  output logic        done,
  input  logic [16:0] cpu_addr,
  input  logic [1:0]  cpu_wrpattern,
  input  logic [31:0] cpu_cache32,
  input  logic [7:0]  cpu_wrdata,
  input  logic        cpu_strobe,
  input  logic        cpu_write,
  output logic [7:0]  cpu_rddata,
  output logic [16:0] vram_addr,
  output logic [1:0]  vram_wrpattern,
  output logic [31:0] vram_cache32,
  output logic [7:0]  vram_wrdata,
  output logic        vram_strobe,
  output logic        vram_write,
  input  logic [7:0]  vram_rddata,
  input  logic [31:0] vram_rddata32
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_DONE} state_t;

  state_t      state_q;
  logic [14:0] src_q;
  logic [14:0] dst_q;
  logic [14:0] cnt_q;
  logic [31:0] data_q;
  logic        fill_q;
  logic        busy_q;
  logic        done_q;

  logic        eng_req;
  logic        eng_write;
  logic        grant;
  logic [16:0] eng_addr;

  // Handshake: the engine holds its request (RD/WR state) until a cycle with
  // cpu_strobe low; that cycle is the grant and the access is committed.
  always_comb begin
    eng_req   = (state_q == S_RD) || (state_q == S_WR);
    eng_write = (state_q == S_WR);
    eng_addr  = eng_write ? {dst_q, 2'b00} : {src_q, 2'b00};
    grant     = eng_req && !cpu_strobe;
  end

  always_comb begin
    vram_addr      = 17'd0;
    vram_wrpattern = 2'b00;
    vram_cache32   = 32'd0;
    vram_wrdata    = 8'd0;
    vram_strobe    = 1'b0;
    vram_write     = 1'b0;
    if (cpu_strobe) begin
      vram_addr      = cpu_addr;
      vram_wrpattern = cpu_wrpattern;
      vram_cache32   = cpu_cache32;
      vram_wrdata    = cpu_wrdata;
      vram_strobe    = 1'b1;
      vram_write     = cpu_write;
    end else if (eng_req) begin
      vram_addr      = eng_addr;
      vram_wrpattern = eng_write ? 2'b11 : 2'b00;
      vram_cache32   = data_q;
      vram_wrdata    = data_q[7:0];
      vram_strobe    = 1'b1;
      vram_write     = eng_write;
    end
  end

  assign cpu_rddata = vram_rddata;
  assign busy       = busy_q;
  assign done       = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      src_q   <= 15'd0;
      dst_q   <= 15'd0;
      cnt_q   <= 15'd0;
      data_q  <= 32'd0;
      fill_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            src_q  <= cfg_src;
            dst_q  <= cfg_dst;
            cnt_q  <= cfg_len;
            fill_q <= cfg_fill_mode;
            data_q <= cfg_fill_data;
            busy_q <= 1'b1;
            if (cfg_len == 15'd0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else if (cfg_fill_mode) begin
              state_q <= S_WR;
            end else begin
              state_q <= S_RD;
            end
          end
        end
        S_RD: begin
          if (grant) state_q <= S_CAP;
        end
        // Read data is only valid the cycle after the grant, so capture here
        // regardless of what the CPU is doing this cycle.
        S_CAP: begin
          data_q  <= vram_rddata32;
          state_q <= S_WR;
        end
        S_WR: begin
          if (grant) begin
            dst_q <= dst_q + 15'd1;
            if (!fill_q) src_q <= src_q + 15'd1;
            cnt_q <= cnt_q - 15'd1;
            if (cnt_q == 15'd1) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else if (!fill_q) begin
              state_q <= S_RD;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
